mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one pipelined Q2.22 Booth/Wallace multiplier (fixed latency, no stall) among N_REQ requesters,
//  e.g. IIR biquad sections computing coefficient*state products.
//  Round-robin issue at one operation per clock. Each issued product is tagged with its requester ID
//  in a shift pipeline matched to the multiplier latency, and the result is routed back to that requester.
//  Sits between the filter section controllers and the single shared multiplier instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  ID_W     2   requester ID width, >= ceil(log2(N_REQ))
//  MUL_LAT  6   multiplier latency, in cycles from mul_valid_in high to mul_valid_out high
//  DW       24  operand/result width (Q2.22)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  en            in   1         1 = grant new requests; 0 = drain in-flight work, then go idle
//  req_valid     in   N_REQ     per-requester request valid, held until accepted
//  req_a         in   N_REQ*DW  operand a; requester i in bits [i*DW +: DW]
//  req_b         in   N_REQ*DW  operand b; same packing as req_a
//  req_ready     out  N_REQ     one-hot grant, combinational; transfer = req_valid[i] & req_ready[i]
//  resp_valid    out  N_REQ     one-hot result pulse for the owning requester
//  resp_p        out  DW        result, shared bus, qualified by resp_valid
//  mul_a         out  DW        to multiplier input a
//  mul_b         out  DW        to multiplier input b
//  mul_valid_in  out  1         to multiplier valid_in
//  mul_p         in   DW        from multiplier p (held-type output)
//  mul_valid_out in   1         from multiplier valid_out (pulse)
//  busy          out  1         1 while state != IDLE
//  err           out  1         sticky tag/valid mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, rr_ptr=0, tag pipe cleared, in-flight count=0.
//   All outputs 0: req_ready, resp_valid, resp_p, mul_a/b, mul_valid_in, busy, err.
//   Reset mid-operation discards all in-flight tags; any multiplier pulse arriving afterwards is ignored
//   (no resp_valid). With ERRCHK it does not set err.
//  FSM:
//   IDLE  -> RUN   when en=1
//   RUN   -> DRAIN when en=0
//   DRAIN -> RUN   when en=1
//   DRAIN -> IDLE  when in-flight count=0 and en=0
//  Grants only in RUN. req_ready=0 in IDLE and DRAIN.
//  Arbitration: lowest index i >= rr_ptr (wrapping modulo N_REQ) with req_valid[i]=1 gets req_ready[i]=1.
//   At most one grant per cycle. On a transfer, rr_ptr <= (i+1) mod N_REQ; otherwise rr_ptr holds.
//  Issue (registered): for a transfer in cycle c, the multiplier sees
//   mul_valid_in=1, mul_a=req_a[i], mul_b=req_b[i] in cycle c+1.
//   With no transfer, mul_valid_in=0 and mul_a/mul_b hold their last values.
//  Tag pipe: MUL_LAT+1 stage shift register of {v,id}. It is loaded with {1,i} on a transfer and
//   {0,x} otherwise; the head aligns with mul_valid_out in cycle c+1+MUL_LAT.
//  Response (registered): on mul_valid_out with head v=1,
//   resp_valid[head.id]=1 and resp_p=mul_p in cycle c+MUL_LAT+2 (8 cycles for MUL_LAT=6).
//   resp_valid is a single-cycle pulse; resp_p holds between pulses.
//  Back-to-back transfers in consecutive cycles give consecutive responses in issue order. There is no
//   response backpressure: requesters always sink resp_valid.
//  In-flight count: +1 on transfer, -1 on response, both in the same cycle -> unchanged.
//   Range 0..MUL_LAT+1. No wrap is possible.
//  Saturation and rounding are done by the multiplier; this block passes mul_p through unmodified.
// CONFIGURATION
//  MULT_ARB_ERRCHK_EN defined:
//   err <= 1 (sticky until rst) when mul_valid_out=1 with head v=0, or head v=1 with mul_valid_out=0.
//   On a missing pulse no resp_valid is produced for that tag; the count still decrements.
//  MULT_ARB_ERRCHK_EN undefined:
//   err tied to 0; routing uses head v only and ignores a stray mul_valid_out.
// TESTING
//  T1 single: en=1, req_valid=0001, a=b=24'h200000 (0.5)
//     -> req_ready=0001 at c; mul_valid_in at c+1; resp_valid=0001, resp_p=24'h100000 at c+8.
//  T2 round-robin: all four req_valid held 1 for 8 cycles
//     -> grant order 0,1,2,3,0,1,2,3; responses return in the same order on consecutive cycles.
//  T3 ptr wrap: rr_ptr=3, only req 3 and req 0 valid -> grant 3, then 0; rr_ptr ends at 1.
//  T4 drain: en->0 with 5 ops in flight
//     -> req_ready=0 immediately; all 5 responses delivered; busy falls the cycle after the count hits 0.
//  T5 reset mid-flight: rst pulse with 3 ops in flight
//     -> all outputs 0; the late mul_valid_out pulses produce no resp_valid; err stays 0.
//  T6 (ERRCHK) inject mul_valid_out=1 with empty pipe -> err=1 next cycle, stays 1 until rst.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one pipelined Q2.22 multiplier (fixed latency, no stall) among
// N_REQ requesters. Requests are granted round-robin, one per clock. Each
// issued operation is tagged with its requester ID in a shift pipeline that
// is aligned with the multiplier latency. The product is then routed back to
// that requester as a one-cycle resp_valid pulse on the shared resp_p bus.
//
// Optional build macro:
//   MULT_ARB_ERRCHK_EN - when defined, err is a sticky flag. It sets when a
//                        multiplier valid pulse and the head tag disagree.
//                        When undefined, err is tied to 0.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              1 = grant new requests, 0 = drain in-flight work then idle
//   req_valid       per-requester request valid (held until accepted)
//   req_a, req_b    packed operands, requester i in bits [i*DW +: DW]
//   req_ready       one-hot combinational grant
//   resp_valid      one-hot result pulse for the owning requester
//   resp_p          shared result bus, holds between pulses
//   mul_a, mul_b    registered operands to the multiplier
//   mul_valid_in    registered issue strobe to the multiplier
//   mul_p           multiplier product (held-type)
//   mul_valid_out   multiplier result pulse
//   busy            1 while not idle
//   err             sticky tag/valid mismatch flag (ERRCHK build only)
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 6,
  parameter int DW      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    resp_valid,
  output logic [DW-1:0]       resp_p,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  output logic                mul_valid_in,
  input  logic [DW-1:0]       mul_p,
  input  logic                mul_valid_out,
  output logic                busy,
  output logic                err
);

  // The tag pipe has one more stage than the multiplier latency because the
  // issue register adds a cycle in front of the multiplier.
  localparam int PIPE_N = MUL_LAT + 1;
  localparam int CNT_W  = $clog2(MUL_LAT + 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PIPE_N-1:0]       tag_v_q, tag_v_d;
  logic [PIPE_N*ID_W-1:0]  tag_id_q, tag_id_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]           mul_a_q, mul_a_d;
  logic [DW-1:0]           mul_b_q, mul_b_d;
  logic                    mul_vld_q, mul_vld_d;
  logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic [DW-1:0]           resp_p_q, resp_p_d;

  // Arbitration results
  logic                    xfer;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W:0]           cand_w;
  logic [ID_W-1:0]         cand;
  logic [N_REQ-1:0]        grant_oh;
  logic [DW-1:0]           sel_a;
  logic [DW-1:0]           sel_b;

  // Tag pipe head
  logic                    head_v;
  logic [ID_W-1:0]         head_id;
  logic                    deliver;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: scan from rr_ptr upward, wrapping, and take the first
  // valid requester. Grants are also gated by en so that dropping en stops
  // issue in the same cycle rather than one cycle later.
  // -------------------------------------------------------------------------
  always_comb begin
    xfer     = 1'b0;
    grant_id = '0;
    cand_w   = '0;
    cand     = '0;
    if (state_q == RUN && en) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (cand_w >= (ID_W+1)'(N_REQ)) begin
          cand_w = cand_w - (ID_W+1)'(N_REQ);
        end
        cand = cand_w[ID_W-1:0];
        if (!xfer && req_valid[cand]) begin
          xfer     = 1'b1;
          grant_id = cand;
        end
      end
    end
  end

  // One-hot grant and operand select for the winning requester.
  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    if (xfer) begin
      grant_oh[grant_id] = 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = req_a[i*DW +: DW];
        sel_b = req_b[i*DW +: DW];
      end
    end
  end

  assign req_ready = grant_oh;

  // -------------------------------------------------------------------------
  // Issue register, tag pipe, pointer and in-flight count
  // -------------------------------------------------------------------------
  assign head_v  = tag_v_q[PIPE_N-1];
  assign head_id = tag_id_q[PIPE_N*ID_W-1 -: ID_W];

  // A result is routed only when a live tag meets a multiplier pulse. Stray
  // pulses (no live tag, e.g. leftovers from before a reset) are ignored. A
  // live tag without a pulse produces no response.
  assign deliver = head_v & mul_valid_out;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_vld_d = xfer;
    if (xfer) begin
      mul_a_d = sel_a;
      mul_b_d = sel_b;
      if (grant_id == ID_W'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id + ID_W'(1);
      end
    end

    // Newest entry enters at stage 0; the head is the oldest stage.
    tag_v_d  = {tag_v_q[PIPE_N-2:0], xfer};
    tag_id_d = {tag_id_q[(PIPE_N-1)*ID_W-1:0], grant_id};

    // The count tracks issued tags still in the pipe. A tag leaves when it
    // reaches the head, whether or not its pulse arrived.
    cnt_d = cnt_q;
    if (xfer && !head_v) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!xfer && head_v) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Response routing
  // -------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = '0;
    resp_p_d     = resp_p_q;
    if (deliver) begin
      resp_valid_d[head_id] = 1'b1;
      resp_p_d              = mul_p;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_vld_q    <= 1'b0;
      resp_valid_q <= '0;
      resp_p_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_vld_q    <= mul_vld_d;
      resp_valid_q <= resp_valid_d;
      resp_p_q     <= resp_p_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_valid_in = mul_vld_q;
  assign resp_valid   = resp_valid_q;
  assign resp_p       = resp_p_q;
  assign busy         = (state_q != IDLE);

`ifdef MULT_ARB_ERRCHK_EN
  // -------------------------------------------------------------------------
  // Tag/valid consistency check. After reset the multiplier may still emit
  // pulses for work issued before the reset, so stray pulses are not flagged
  // until the multiplier has had time to flush.
  // -------------------------------------------------------------------------
  logic             err_q, err_d;
  logic [CNT_W-1:0] guard_q, guard_d;

  always_comb begin
    guard_d = guard_q;
    if (guard_q != '0) begin
      guard_d = guard_q - CNT_W'(1);
    end
    err_d = err_q;
    if (head_v && !mul_valid_out) begin
      err_d = 1'b1;
    end
    if (!head_v && mul_valid_out && guard_q == '0) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      guard_q <= CNT_W'(MUL_LAT + 1);
    end else begin
      err_q   <= err_d;
      guard_q <= guard_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
